// File: rtl/cache_fill_fsm_pkg.sv
// Shared widths, FSM state type and block-alignment helper for the cache miss fill controller.
package cache_pkg;

  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFFSET_W        = 4;
  localparam int WORD_SEL_W      = $clog2(WORDS_PER_BLOCK);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Miss request, main-memory read and cache-array write signals of the fill controller.
interface cache_fill_fsm_if;
  import cache_pkg::*;

  logic                  miss_detected;
  logic [ADDR_W-1:0]     miss_address;
  logic                  fsm_busy;
  logic                  memory_read;
  logic [ADDR_W-1:0]     memory_address;
  logic [DATA_W-1:0]     memory_data;
  logic                  memory_data_valid;
  logic                  write_data_array;
  logic [WORD_SEL_W-1:0] array_word_sel;
  logic [DATA_W-1:0]     array_data;
  logic                  write_tag_array;

  modport master (
    input  miss_detected, miss_address, memory_data, memory_data_valid,
    output fsm_busy, memory_read, memory_address,
           write_data_array, array_word_sel, array_data, write_tag_array
  );

  modport slave (
    output miss_detected, miss_address, memory_data, memory_data_valid,
    input  fsm_busy, memory_read, memory_address,
           write_data_array, array_word_sel, array_data, write_tag_array
  );

endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word counter for one side of a block fill; done flags the beat that completes the block.
module fill_counter
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  output logic [WORD_SEL_W-1:0] count,
  output logic                  done
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WORD_SEL_W'(1);
    end
  end

  assign done = en && (count == WORD_SEL_W'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: issues eight pipelined word reads and writes the returns into the arrays.
// Optional CACHE_FILL_PERF_EN adds saturating fill_count / busy_cycles counters.
//
// state | meaning
// IDLE  | no fill; waits for miss_detected, then latches the block base
// FILL  | reads issue back to back while returns are written as they arrive
module cache_fill_fsm
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  cache_fill_fsm_if.master fillBus
`ifdef CACHE_FILL_PERF_EN
  ,
  output logic [15:0]      fill_count,
  output logic [15:0]      busy_cycles
`endif
);

  fill_state_e           state, nextState;
  logic [ADDR_W-1:0]     base;
  logic                  issuedAll;
  logic [WORD_SEL_W-1:0] issueCnt, recvCnt;
  logic                  inFill, clrCnt;
  logic                  issueEn, issueDone, recvEn, recvDone, protoErr;

  assign inFill  = (state == FILL);
  assign clrCnt  = !inFill;
  assign issueEn = inFill && !issuedAll;

  // A return with nothing outstanding is dropped rather than written.
  assign protoErr = inFill && fillBus.memory_data_valid && !issuedAll && (recvCnt == issueCnt);
  assign recvEn   = inFill && fillBus.memory_data_valid && !protoErr;

  fill_counter uIssueCnt (
    .clk  (clk),
    .rst  (rst),
    .en   (issueEn),
    .clr  (clrCnt),
    .count(issueCnt),
    .done (issueDone)
  );

  fill_counter uRecvCnt (
    .clk  (clk),
    .rst  (rst),
    .en   (recvEn),
    .clr  (clrCnt),
    .count(recvCnt),
    .done (recvDone)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base      <= '0;
      issuedAll <= 1'b0;
    end else begin
      if (!inFill && fillBus.miss_detected) begin
        base <= block_base(fillBus.miss_address);
      end
      if (!inFill) begin
        issuedAll <= 1'b0;
      end else if (issueDone) begin
        issuedAll <= 1'b1;
      end
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (fillBus.miss_detected) nextState = FILL;
      FILL:    if (recvDone) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    fillBus.fsm_busy         = 1'b0;
    fillBus.memory_read      = 1'b0;
    fillBus.memory_address   = '0;
    fillBus.write_data_array = 1'b0;
    fillBus.array_word_sel   = '0;
    fillBus.array_data       = '0;
    fillBus.write_tag_array  = 1'b0;
    if (inFill) begin
      fillBus.fsm_busy = 1'b1;
      if (!issuedAll) begin
        fillBus.memory_read    = 1'b1;
        fillBus.memory_address = base + ADDR_W'({issueCnt, 1'b0});
      end
      if (recvEn) begin
        fillBus.write_data_array = 1'b1;
        fillBus.array_word_sel   = recvCnt;
        fillBus.array_data       = fillBus.memory_data;
      end
      fillBus.write_tag_array = recvDone;
    end
  end

  assert property (@(posedge clk) disable iff (rst) !protoErr);

`ifdef CACHE_FILL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_count  <= '0;
      busy_cycles <= '0;
    end else begin
      if (recvDone && fill_count != 16'hFFFF) begin
        fill_count <= fill_count + 16'd1;
      end
      if (inFill && busy_cycles != 16'hFFFF) begin
        busy_cycles <= busy_cycles + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: pipelined memory model plus a schedule-based expectation model.
module tb_cache_fill_fsm;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_fill_fsm_if ifc();

`ifdef CACHE_FILL_PERF_EN
  logic [15:0] fillCount, busyCycles;
`endif

  cache_fill_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .fillBus    (ifc)
`ifdef CACHE_FILL_PERF_EN
    ,
    .fill_count (fillCount),
    .busy_cycles(busyCycles)
`endif
  );

  typedef struct {
    int          due;
    logic [15:0] data;
  } ret_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  ret_t pend[$];
  int   lastDue = -100;
  int   retCount = 0;
  int   memLat = 4;
  bit   gapMode = 1'b0;

  logic        missHold = 1'b0;
  logic [15:0] missAddr = 16'h0000;
  logic        rstReq = 1'b1;
  bit          busyWas = 1'b0;

  bit          mFill = 1'b0;
  int          mStart = 0;
  logic [15:0] mBase = 16'h0000;
  int          mBeats = 0;

  int          firstReadRel, readCount, tagRel, tagCount, fallRel;
  logic [15:0] firstReadAddr, lastReadAddr;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic clearRec();
    firstReadRel = -1; readCount = 0; tagRel = -1; tagCount = 0; fallRel = -1;
    firstReadAddr = 16'h0000; lastReadAddr = 16'h0000;
  endtask

  task automatic modelCheck();
    int          rel, issuedBefore;
    bit          readExp, wrExp, tagExp, wasFill;
    logic [15:0] addrExp, dataExp;
    logic [2:0]  selExp;
    rel = cyc - mStart;
    issuedBefore = rel - 1;
    if (issuedBefore < 0) issuedBefore = 0;
    if (issuedBefore > 8) issuedBefore = 8;
    readExp = mFill && rel >= 1 && rel <= 8;
    addrExp = readExp ? mBase + 16'(2 * (rel - 1)) : 16'h0000;
    wrExp   = mFill && ifc.memory_data_valid && (mBeats < issuedBefore);
    selExp  = wrExp ? 3'(mBeats) : 3'd0;
    dataExp = wrExp ? memWord(mBase + 16'(2 * mBeats)) : 16'h0000;
    tagExp  = wrExp && (mBeats == 7);
    check("outputs",
          {25'd0, ifc.fsm_busy, ifc.memory_read, ifc.memory_address, ifc.write_data_array,
           ifc.array_word_sel, ifc.array_data, ifc.write_tag_array},
          {25'd0, mFill, readExp, addrExp, wrExp, selExp, dataExp, tagExp});

    if (ifc.memory_read) begin
      if (readCount == 0) begin
        firstReadRel = rel;
        firstReadAddr = ifc.memory_address;
      end
      lastReadAddr = ifc.memory_address;
      readCount++;
    end
    if (ifc.write_tag_array) begin
      tagRel = rel;
      tagCount++;
    end
    if (busyWas && !ifc.fsm_busy && fallRel < 0) fallRel = rel;

    wasFill = mFill;
    if (wrExp) mBeats++;
    if (tagExp) mFill = 1'b0;
    if (rst) begin
      mFill = 1'b0;
    end else if (!wasFill && ifc.miss_detected) begin
      mFill = 1'b1;
      mStart = cyc;
      mBase = {missAddr[15:4], 4'h0};
      mBeats = 0;
    end
  endtask

  task automatic cycle();
    int due, gap;
    @(posedge clk);
    cyc++;
    if (rst) begin
      pend.delete();
      lastDue = -100;
      retCount = 0;
    end
    #1;
    rst = rstReq;
    if (missHold && busyWas && !ifc.fsm_busy) missHold = 1'b0;
    ifc.miss_detected = missHold;
    ifc.miss_address = missAddr;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ifc.memory_data_valid = 1'b1;
      ifc.memory_data = pend[0].data;
      void'(pend.pop_front());
    end else begin
      ifc.memory_data_valid = 1'b0;
      ifc.memory_data = 16'hDEAD ^ 16'(cyc);
    end
    @(negedge clk);
    modelCheck();
    if (ifc.memory_read) begin
      gap = (gapMode && (retCount % 2 == 1)) ? 7 : 1;
      due = cyc + (gapMode ? 1 : memLat);
      if (due < lastDue + gap) due = lastDue + gap;
      pend.push_back('{due, memWord(ifc.memory_address)});
      lastDue = due;
      retCount++;
    end
    busyWas = ifc.fsm_busy;
  endtask

  task automatic startMiss(input logic [15:0] addr);
    clearRec();
    missAddr = addr;
    missHold = 1'b1;
  endtask

  task automatic waitDone(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (!missHold && !ifc.fsm_busy) return;
    end
    checks++;
    failures++;
    $display("FAIL %s timeout: busy still %0b after %0d cycles, required 0", name, ifc.fsm_busy, budget);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    ifc.miss_detected = 1'b0;
    ifc.miss_address = 16'h0000;
    ifc.memory_data = 16'h0000;
    ifc.memory_data_valid = 1'b0;
    clearRec();

    rstReq = 1'b1;
    repeat (3) cycle();
    check("reset_outputs",
          {ifc.fsm_busy, ifc.memory_read, ifc.memory_address, ifc.write_data_array,
           ifc.array_word_sel, ifc.array_data, ifc.write_tag_array}, 64'd0);
    rstReq = 1'b0;
    repeat (2) cycle();

    // basic fill, 4-cycle memory
    memLat = 4;
    startMiss(16'h1234);
    waitDone(40, "fill_1234");
    check("t1_first_read_cycle", 64'(firstReadRel), 64'd1);
    check("t1_first_addr", 64'(firstReadAddr), 64'h1230);
    check("t1_last_addr", 64'(lastReadAddr), 64'h123E);
    check("t1_read_count", 64'(readCount), 64'd8);
    check("t1_tag_cycle", 64'(tagRel), 64'd12);
    check("t1_tag_count", 64'(tagCount), 64'd1);
    check("t1_busy_fall_cycle", 64'(fallRel), 64'd13);
    repeat (2) cycle();

    // top-of-memory block
    startMiss(16'hFFFE);
    waitDone(40, "fill_fffe");
    check("t2_first_addr", 64'(firstReadAddr), 64'hFFF0);
    check("t2_last_addr", 64'(lastReadAddr), 64'hFFFE);
    check("t2_read_count", 64'(readCount), 64'd8);
    repeat (2) cycle();

    // gapped returns: 1-cycle memory with 6-cycle stalls
    gapMode = 1'b1;
    retCount = 0;
    startMiss(16'h0A5A);
    waitDone(80, "fill_gaps");
    gapMode = 1'b0;
    check("t3_tag_count", 64'(tagCount), 64'd1);
    check("t3_tag_cycle", 64'(tagRel), 64'd33);
    check("t3_read_count", 64'(readCount), 64'd8);
    repeat (2) cycle();

    // reset in cycle 6 of a fill
    startMiss(16'h1000);
    repeat (6) cycle();
    rstReq = 1'b1;
    missHold = 1'b0;
    cycle();
    rstReq = 1'b0;
    cycle();
    check("t4_outputs_after_rst",
          {ifc.fsm_busy, ifc.memory_read, ifc.memory_address, ifc.write_data_array,
           ifc.array_word_sel, ifc.array_data, ifc.write_tag_array}, 64'd0);
    check("t4_reads_before_rst", 64'(readCount), 64'd6);
    check("t4_no_tag_before_rst", 64'(tagCount), 64'd0);
    cycle();
    startMiss(16'h0040);
    waitDone(40, "fill_0040");
    check("t4_first_addr", 64'(firstReadAddr), 64'h0040);
    check("t4_read_count", 64'(readCount), 64'd8);
    check("t4_tag_cycle", 64'(tagRel), 64'd12);

    // back-to-back misses
    startMiss(16'h0100);
    waitDone(40, "fill_0100");
    check("t5_first_addr_a", 64'(firstReadAddr), 64'h0100);
    startMiss(16'h0200);
    waitDone(40, "fill_0200");
    check("t5_first_addr_b", 64'(firstReadAddr), 64'h0200);
    check("t5_first_read_cycle_b", 64'(firstReadRel), 64'd1);
    check("t5_tag_count_b", 64'(tagCount), 64'd1);
    repeat (2) cycle();

`ifdef CACHE_FILL_PERF_EN
    rstReq = 1'b1;
    cycle();
    rstReq = 1'b0;
    cycle();
    for (int i = 0; i < 3; i++) begin
      startMiss(16'h0300 + 16'(i * 16'h0020));
      waitDone(40, "fill_perf");
      cycle();
    end
    $display("perf: requests=3 fills=%0d busy_cycles=%0d", fillCount, busyCycles);
    check("perf_fill_count", 64'(fillCount), 64'd3);
    check("perf_busy_cycles", 64'(busyCycles), 64'd36);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
